haze_axis_tx: RTL and testbench
===============================

Name: haze_axis_tx

Overview:
Output stage directly downstream of the haze-removal pixel pipeline (ALE/TE/SRSC chain). It takes the free-running 24-bit pixel stream and its valid strobe and buffers them in a small FIFO. It drives an AXI4-Stream master with TUSER on start-of-frame and TLAST on the last pixel of each frame. The upstream pipeline cannot be stalled, so the block absorbs short TREADY back-pressure, reports any loss through a sticky overflow flag, and keeps frame/position tracking aligned.

Parameters:
IMG_WIDTH, 512, pixels per line
IMG_HEIGHT, 512, lines per frame
FIFO_DEPTH, 16, buffer entries, power of 2, >=4
ALMOST_FULL_TH, 12, occupancy at or above which almost_full asserts

Ports:
clk  in  1  single clock
rst  in  1  asynchronous, active-high reset
enable  in  1  input-side enable; low = input ignored, position counters frozen
in_pixel  in  24  {R[23:16],G[15:8],B[7:0]} from SRSC stage
in_valid  in  1  pixel strobe, one pixel per cycle max, no back-pressure
almost_full  out  1  occupancy >= ALMOST_FULL_TH
overflow  out  1  sticky: a valid pixel was dropped because FIFO full
M_AXIS_TDATA  out  32  {8'h00, pixel}
M_AXIS_TVALID  out  1  data available
M_AXIS_TREADY  in  1  downstream ready
M_AXIS_TLAST  out  1  last pixel of frame
M_AXIS_TUSER  out  1  first pixel of frame (SOF)
frame_done  out  1  one-cycle pulse when a TLAST beat transfers
frame_count  out  16  frames transferred, wraps 0xFFFF->0

Behaviour:
- Reset (async assert, sync release): FIFO empty, col=row=0, all outputs 0 (TDATA=0, TVALID=0, TLAST=0, TUSER=0, overflow=0, frame_done=0, frame_count=0, almost_full=0). Reset mid-frame discards buffered data; the next accepted pixel is SOF.
- Input event = in_valid & enable. On each event, tag the pixel with sof=(col==0 && row==0) and last=(col==IMG_WIDTH-1 && row==IMG_HEIGHT-1). Then advance col; col wraps to 0 and row increments; row wraps to 0 after the last line.
- Push on event when not full, or when full with a pop in the same cycle (simultaneous push/pop at full is accepted, no drop).
- Full without pop: pixel dropped, overflow<=1 (held until rst). Position counters still advance so later frames stay aligned. If the dropped pixel carried last, that frame produces no TLAST and no frame_done.
- FIFO entry = 26 bits {sof,last,pixel}. Output is first-word-fall-through from a registered output stage.
- Latency: event at cycle N into an empty FIFO gives TVALID=1 with that pixel at cycle N+1.
- Handshake: transfer = TVALID & TREADY. While TVALID=1 and TREADY=0, TDATA/TLAST/TUSER stay stable. TVALID never drops without a transfer. TVALID does not depend combinationally on TREADY.
- Back-to-back transfers at 1 beat/cycle when TREADY is held high.
- enable low: no push and counters frozen; the output side keeps draining.
- frame_done pulses the cycle after the TLAST transfer; frame_count increments in that same cycle.
- almost_full is combinational from registered occupancy, where occupancy counts FIFO plus the output register.

Decomposition:
- Package haze_axis_pkg: PIX_W=24, TDATA_W=32, ENTRY_W=26, tag bit indices (TAG_SOF=25, TAG_LAST=24).
- One sub-module, pix_sync_fifo: parameterised width/depth, first-word-fall-through, count output, push/pop, full/empty. Top holds position counters, tagging, overflow, AXI output register and frame counters.

Test Plan:
- W=4,H=2,DEPTH=4; 8 consecutive valid pixels 0x000001..0x000008, TREADY=1 -> 8 beats one cycle later, TUSER on beat 1 only, TLAST on beat 8 only, frame_done pulse, frame_count=1, overflow=0.
- Same frame, TREADY=0 for cycles 2-5 -> TDATA for beat 1 held stable while stalled, all 8 pixels delivered in order, overflow=0, almost_full asserted when occupancy reaches TH.
- TREADY=0 for whole frame with DEPTH=4 -> pixels 6..8 dropped, overflow=1 and held, no TLAST seen, frame_count=0; next frame starts with TUSER on its first pixel.
- Full FIFO with TREADY=1 and in_valid=1 in the same cycle -> no drop, overflow stays 0, order preserved.
- enable=0 for 3 cycles mid-line with in_valid=1 -> those pixels ignored, col frozen, TLAST still on the 8th enabled pixel.
- rst pulsed after pixel 3 with 2 beats pending -> TVALID=0 immediately, pending beats lost, next pixel tagged TUSER, frame_count=0.

Source files
------------

// File: rtl/haze_axis_pkg.sv
// haze_axis_pkg
//   Shared constants for the haze-removal AXI4-Stream output stage.
//   PIX_W    : width of one RGB pixel {R,G,B}
//   TDATA_W  : AXI4-Stream data width (pixel zero-extended)
//   ENTRY_W  : FIFO entry width, {sof, last, pixel}
//   TAG_SOF / TAG_LAST : bit positions of the frame tags inside an entry
package haze_axis_pkg;

  localparam int PIX_W    = 24;
  localparam int TDATA_W  = 32;
  localparam int ENTRY_W  = 26;
  localparam int TAG_SOF  = 25;
  localparam int TAG_LAST = 24;

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/haze_axis_tx_pix_sync_fifo.sv
// pix_sync_fifo
//   Small synchronous first-word-fall-through FIFO: the head entry is
//   visible on pop_data whenever empty is low.
//   Ports:
//     clk, rst          : clock, asynchronous active-high reset
//     push, push_data   : write request; accepted when not full, or when
//                         full and a pop happens in the same cycle
//     pop, pop_data     : read request / head entry
//     full, empty       : status flags
//     count             : number of stored entries (0..DEPTH)
module pix_sync_fifo #(
  parameter int WIDTH = 26,
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  output logic [WIDTH-1:0]       pop_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      cnt;
  logic             do_push;
  logic             do_pop;

  assign empty    = (cnt == '0);
  assign full     = (cnt == (AW+1)'(DEPTH));
  assign count    = cnt;
  assign pop_data = mem[rd_ptr];

  assign do_pop  = pop & ~empty;
  // A pop frees the slot this cycle, so a push into a full FIFO still fits.
  assign do_push = push & (~full | do_pop);

  // Storage is not reset; stale contents are unreachable once pointers clear.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // DEPTH is a power of two, so pointers wrap naturally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/haze_axis_tx.sv
// haze_axis_tx
//   AXI4-Stream master output stage for the haze-removal pixel pipeline.
//   Pixels are tagged with start/end-of-frame, buffered in a FIFO behind a
//   registered output beat, and dropped (sticky overflow) when no room.
//   Ports:
//     clk, rst               : clock, asynchronous active-high reset
//     enable                 : input-side enable (low: ignore input, freeze position)
//     in_pixel, in_valid     : free-running pixel stream, no back-pressure
//     almost_full            : occupancy (FIFO + output beat) >= ALMOST_FULL_TH
//     overflow               : sticky, a valid pixel was dropped
//     M_AXIS_*               : AXI4-Stream master (TUSER = SOF, TLAST = end of frame)
//     frame_done             : one-cycle pulse after a TLAST beat transfers
//     frame_count            : frames transferred, wrapping
module haze_axis_tx
  import haze_axis_pkg::*;
#(
  parameter int IMG_WIDTH      = 512,
  parameter int IMG_HEIGHT     = 512,
  parameter int FIFO_DEPTH     = 16,
  parameter int ALMOST_FULL_TH = 12
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               enable,
  input  logic [PIX_W-1:0]   in_pixel,
  input  logic               in_valid,
  output logic               almost_full,
  output logic               overflow,
  output logic [TDATA_W-1:0] M_AXIS_TDATA,
  output logic               M_AXIS_TVALID,
  input  logic               M_AXIS_TREADY,
  output logic               M_AXIS_TLAST,
  output logic               M_AXIS_TUSER,
  output logic               frame_done,
  output logic [15:0]        frame_count
);

  localparam int COL_W = cnt_width(IMG_WIDTH);
  localparam int ROW_W = cnt_width(IMG_HEIGHT);
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam int OCC_W = CNT_W + 1;
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_WIDTH - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_HEIGHT - 1);
  localparam logic [OCC_W-1:0] AF_TH    = OCC_W'(ALMOST_FULL_TH);

  logic [COL_W-1:0]   col_reg;
  logic [ROW_W-1:0]   row_reg;
  logic [TDATA_W-1:0] tdata_reg;
  logic               tvalid_reg;
  logic               tlast_reg;
  logic               tuser_reg;
  logic               overflow_reg;
  logic               frame_done_reg;
  logic [15:0]        frame_count_reg;

  logic               in_event;
  logic [ENTRY_W-1:0] in_entry;
  logic               xfer;
  logic               out_free;
  logic               bypass;
  logic               fifo_push;
  logic               fifo_pop;
  logic               drop;
  logic [ENTRY_W-1:0] fifo_data;
  logic [ENTRY_W-1:0] load_entry;
  logic               fifo_full;
  logic               fifo_empty;
  logic [CNT_W-1:0]   fifo_count;
  logic [OCC_W-1:0]   occupancy;

  assign in_event = in_valid & enable;
  assign in_entry = {(col_reg == '0) && (row_reg == '0),
                     (col_reg == COL_LAST) && (row_reg == ROW_LAST),
                     in_pixel};

  assign xfer     = tvalid_reg & M_AXIS_TREADY;
  // Output beat can take new data this cycle if it is empty or leaving.
  assign out_free = ~tvalid_reg | M_AXIS_TREADY;
  assign fifo_pop = out_free & ~fifo_empty;
  // Empty FIFO and free output beat: skip the FIFO for one-cycle latency.
  assign bypass    = in_event & out_free & fifo_empty;
  assign fifo_push = in_event & ~bypass & (~fifo_full | fifo_pop);
  assign drop      = in_event & ~bypass & fifo_full & ~fifo_pop;
  assign load_entry = fifo_pop ? fifo_data : in_entry;

  pix_sync_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (fifo_push),
    .push_data (in_entry),
    .pop       (fifo_pop),
    .pop_data  (fifo_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  // Position advances on every accepted event, dropped or not, so that
  // frame boundaries stay aligned after a loss.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col_reg <= '0;
      row_reg <= '0;
    end else if (in_event) begin
      if (col_reg == COL_LAST) begin
        col_reg <= '0;
        row_reg <= (row_reg == ROW_LAST) ? '0 : row_reg + 1'b1;
      end else begin
        col_reg <= col_reg + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tdata_reg       <= '0;
      tvalid_reg      <= 1'b0;
      tlast_reg       <= 1'b0;
      tuser_reg       <= 1'b0;
      overflow_reg    <= 1'b0;
      frame_done_reg  <= 1'b0;
      frame_count_reg <= '0;
    end else begin
      if (fifo_pop || bypass) begin
        tdata_reg  <= {{(TDATA_W-PIX_W){1'b0}}, load_entry[PIX_W-1:0]};
        tlast_reg  <= load_entry[TAG_LAST];
        tuser_reg  <= load_entry[TAG_SOF];
        tvalid_reg <= 1'b1;
      end else if (xfer) begin
        tvalid_reg <= 1'b0;
      end
      if (drop) overflow_reg <= 1'b1;
      frame_done_reg <= xfer & tlast_reg;
      if (xfer && tlast_reg) frame_count_reg <= frame_count_reg + 16'd1;
    end
  end

  assign occupancy   = {1'b0, fifo_count} + OCC_W'(tvalid_reg);
  assign almost_full = (occupancy >= AF_TH);

  assign M_AXIS_TDATA  = tdata_reg;
  assign M_AXIS_TVALID = tvalid_reg;
  assign M_AXIS_TLAST  = tlast_reg;
  assign M_AXIS_TUSER  = tuser_reg;
  assign overflow      = overflow_reg;
  assign frame_done    = frame_done_reg;
  assign frame_count   = frame_count_reg;

endmodule

// File: tb/tb_haze_axis_tx.sv
// tb_haze_axis_tx
//   Directed bench for haze_axis_tx with a 4x2 frame and a 4-entry FIFO.
//   A cycle-accurate vector table covers the unstalled and stalled frames;
//   hand-written sequences cover overflow, enable gating and mid-frame reset.
module tb_haze_axis_tx;

  logic        clk;
  logic        rst;
  logic        enable;
  logic [23:0] in_pixel;
  logic        in_valid;
  logic        almost_full;
  logic        overflow;
  logic [31:0] tdata;
  logic        tvalid;
  logic        tready;
  logic        tlast;
  logic        tuser;
  logic        frame_done;
  logic [15:0] frame_count;

  haze_axis_tx #(
    .IMG_WIDTH      (4),
    .IMG_HEIGHT     (2),
    .FIFO_DEPTH     (4),
    .ALMOST_FULL_TH (3)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .enable        (enable),
    .in_pixel      (in_pixel),
    .in_valid      (in_valid),
    .almost_full   (almost_full),
    .overflow      (overflow),
    .M_AXIS_TDATA  (tdata),
    .M_AXIS_TVALID (tvalid),
    .M_AXIS_TREADY (tready),
    .M_AXIS_TLAST  (tlast),
    .M_AXIS_TUSER  (tuser),
    .frame_done    (frame_done),
    .frame_count   (frame_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst, en, vld;
    logic [23:0] pix;
    logic        rdy;
    logic        e_tv;
    logic [23:0] e_pix;
    logic        e_tl, e_tu, e_af, e_ovf, e_fd;
    logic [15:0] e_fc;
  } vec_t;

  typedef struct {
    logic [31:0] data;
    logic        last;
    logic        user;
  } beat_t;

  vec_t  vecs[$];
  beat_t beats[$];
  beat_t exp_beats[$];
  int    n_cmp = 0;
  int    n_err = 0;
  int    fd_seen = 0;

  // Record every transfer and every frame_done pulse.
  always @(posedge clk) begin
    if (!rst && tvalid && tready) beats.push_back('{tdata, tlast, tuser});
    if (!rst && frame_done) fd_seen++;
  end

  function automatic vec_t mk(logic r, logic en, logic vld, logic [23:0] pix, logic rdy,
                              logic tv, logic [23:0] ep, logic tl, logic tu,
                              logic af, logic ovf, logic fd, logic [15:0] fc);
    vec_t v;
    v.rst = r; v.en = en; v.vld = vld; v.pix = pix; v.rdy = rdy;
    v.e_tv = tv; v.e_pix = ep; v.e_tl = tl; v.e_tu = tu;
    v.e_af = af; v.e_ovf = ovf; v.e_fd = fd; v.e_fc = fc;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic cyc(input logic en, input logic vld, input logic [23:0] pix, input logic rdy);
    enable = en; in_valid = vld; in_pixel = pix; tready = rdy;
    @(posedge clk);
    #1;
  endtask

  task automatic exp_add(input logic [23:0] pix, input logic last, input logic user);
    exp_beats.push_back('{{8'h00, pix}, last, user});
  endtask

  task automatic check_beats(input string tag);
    chk({tag, "_beat_count"}, beats.size(), exp_beats.size());
    for (int i = 0; i < exp_beats.size() && i < beats.size(); i++) begin
      chk($sformatf("%s_data%0d", tag, i), beats[i].data, exp_beats[i].data);
      chk($sformatf("%s_last%0d", tag, i), beats[i].last, exp_beats[i].last);
      chk($sformatf("%s_user%0d", tag, i), beats[i].user, exp_beats[i].user);
    end
    $display("seq %s: %0d beats collected, %0d expected", tag, beats.size(), exp_beats.size());
  endtask

  initial begin
    rst = 1'b1; enable = 1'b0; in_valid = 1'b0; in_pixel = '0; tready = 1'b0;

    // ---- vector table -------------------------------------------------
    vecs.push_back(mk(1,0,0,24'h0,0, 0,24'h0,0,0,0,0,0,16'd0));
    vecs.push_back(mk(0,0,0,24'h0,1, 0,24'h0,0,0,0,0,0,16'd0));
    // Frame A: 8 pixels, TREADY high, each beat one cycle after its event.
    for (int k = 1; k <= 8; k++)
      vecs.push_back(mk(0,1,1,24'(k),1, 1,24'(k),(k == 8),(k == 1),0,0,0,16'd0));
    vecs.push_back(mk(0,0,0,24'h0,1, 0,24'h0,0,0,0,0,1,16'd1));
    vecs.push_back(mk(0,0,0,24'h0,1, 0,24'h0,0,0,0,0,0,16'd1));
    // Frame B: TREADY low for cycles 2-5; FIFO fills, then push+pop at full.
    vecs.push_back(mk(0,1,1,24'h11,1, 1,24'h11,0,1,0,0,0,16'd1));
    vecs.push_back(mk(0,1,1,24'h12,0, 1,24'h11,0,1,0,0,0,16'd1));
    vecs.push_back(mk(0,1,1,24'h13,0, 1,24'h11,0,1,1,0,0,16'd1));
    vecs.push_back(mk(0,1,1,24'h14,0, 1,24'h11,0,1,1,0,0,16'd1));
    vecs.push_back(mk(0,1,1,24'h15,0, 1,24'h11,0,1,1,0,0,16'd1));
    vecs.push_back(mk(0,1,1,24'h16,1, 1,24'h12,0,0,1,0,0,16'd1));
    vecs.push_back(mk(0,1,1,24'h17,1, 1,24'h13,0,0,1,0,0,16'd1));
    vecs.push_back(mk(0,1,1,24'h18,1, 1,24'h14,0,0,1,0,0,16'd1));
    vecs.push_back(mk(0,0,0,24'h0,1,  1,24'h15,0,0,1,0,0,16'd1));
    vecs.push_back(mk(0,0,0,24'h0,1,  1,24'h16,0,0,1,0,0,16'd1));
    vecs.push_back(mk(0,0,0,24'h0,1,  1,24'h17,0,0,0,0,0,16'd1));
    vecs.push_back(mk(0,0,0,24'h0,1,  1,24'h18,1,0,0,0,0,16'd1));
    vecs.push_back(mk(0,0,0,24'h0,1,  0,24'h0,0,0,0,0,1,16'd2));
    vecs.push_back(mk(0,0,0,24'h0,1,  0,24'h0,0,0,0,0,0,16'd2));

    foreach (vecs[i]) begin
      rst = vecs[i].rst; enable = vecs[i].en; in_valid = vecs[i].vld;
      in_pixel = vecs[i].pix; tready = vecs[i].rdy;
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_tvalid", i), tvalid, vecs[i].e_tv);
      if (vecs[i].e_tv || vecs[i].rst) begin
        chk($sformatf("v%0d_tdata", i), tdata, {8'h00, vecs[i].e_pix});
        chk($sformatf("v%0d_tlast", i), tlast, vecs[i].e_tl);
        chk($sformatf("v%0d_tuser", i), tuser, vecs[i].e_tu);
      end
      chk($sformatf("v%0d_almost_full", i), almost_full, vecs[i].e_af);
      chk($sformatf("v%0d_overflow", i), overflow, vecs[i].e_ovf);
      chk($sformatf("v%0d_frame_done", i), frame_done, vecs[i].e_fd);
      chk($sformatf("v%0d_frame_count", i), frame_count, vecs[i].e_fc);
      $display("vec %0d: tvalid=%b tdata=%h tlast=%b tuser=%b af=%b ovf=%b fd=%b fc=%0d",
               i, tvalid, tdata, tlast, tuser, almost_full, overflow, frame_done, frame_count);
    end

    // ---- overflow: TREADY low for the whole frame ------------------
    beats.delete(); exp_beats.delete(); fd_seen = 0;
    for (int k = 1; k <= 8; k++) begin
      cyc(1, 1, 24'h20 + 24'(k), 0);
      if (k == 5) begin
        chk("ovf_af_at5", almost_full, 1'b1);
        chk("ovf_flag_at5", overflow, 1'b0);
      end
      if (k == 6) chk("ovf_flag_at6", overflow, 1'b1);
    end
    chk("ovf_stall_tvalid", tvalid, 1'b1);
    chk("ovf_stall_tdata", tdata, 32'h21);
    chk("ovf_stall_tuser", tuser, 1'b1);
    for (int k = 0; k < 8; k++) cyc(0, 0, 24'h0, 1);
    for (int k = 1; k <= 5; k++) exp_add(24'h20 + 24'(k), 1'b0, (k == 1));
    check_beats("ovf_drain");
    chk("ovf_sticky", overflow, 1'b1);
    chk("ovf_frame_count", frame_count, 16'd2);
    chk("ovf_no_frame_done", fd_seen, 0);
    chk("ovf_drained_tvalid", tvalid, 1'b0);

    // Next frame after the loss must start with TUSER.
    beats.delete(); exp_beats.delete(); fd_seen = 0;
    for (int k = 1; k <= 8; k++) cyc(1, 1, 24'h30 + 24'(k), 1);
    for (int k = 0; k < 3; k++) cyc(0, 0, 24'h0, 1);
    for (int k = 1; k <= 8; k++) exp_add(24'h30 + 24'(k), (k == 8), (k == 1));
    check_beats("post_ovf");
    chk("post_ovf_frame_count", frame_count, 16'd3);
    chk("post_ovf_frame_done", fd_seen, 1);
    chk("post_ovf_sticky", overflow, 1'b1);

    // ---- enable gating mid-line --------------------------------------
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_overflow", overflow, 1'b0);
    chk("rst_frame_count", frame_count, 16'd0);
    chk("rst_tvalid", tvalid, 1'b0);
    beats.delete(); exp_beats.delete(); fd_seen = 0;
    for (int k = 1; k <= 11; k++) cyc(!(k >= 3 && k <= 5), 1'b1, 24'h40 + 24'(k), 1'b1);
    for (int k = 0; k < 3; k++) cyc(0, 0, 24'h0, 1);
    exp_add(24'h41, 0, 1); exp_add(24'h42, 0, 0);
    exp_add(24'h46, 0, 0); exp_add(24'h47, 0, 0); exp_add(24'h48, 0, 0);
    exp_add(24'h49, 0, 0); exp_add(24'h4A, 0, 0); exp_add(24'h4B, 1, 0);
    check_beats("enable");
    chk("enable_frame_count", frame_count, 16'd1);
    chk("enable_frame_done", fd_seen, 1);

    // ---- reset mid-frame with beats pending --------------------------
    beats.delete(); exp_beats.delete();
    for (int k = 1; k <= 3; k++) cyc(1, 1, 24'h50 + 24'(k), 0);
    chk("mrst_pre_tvalid", tvalid, 1'b1);
    chk("mrst_pre_tdata", tdata, 32'h51);
    chk("mrst_pre_af", almost_full, 1'b1);
    rst = 1'b1;
    #1;
    chk("mrst_async_tvalid", tvalid, 1'b0);
    chk("mrst_async_af", almost_full, 1'b0);
    chk("mrst_async_fc", frame_count, 16'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    cyc(1, 1, 24'h61, 1);
    chk("mrst_next_tvalid", tvalid, 1'b1);
    chk("mrst_next_tdata", tdata, 32'h61);
    chk("mrst_next_tuser", tuser, 1'b1);
    cyc(0, 0, 24'h0, 1);
    exp_add(24'h61, 0, 1);
    check_beats("mrst");
    chk("mrst_frame_count", frame_count, 16'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
